generic_stream_tx: RTL and testbench
====================================

GENERIC_STREAM_TX -- requirements
Module: generic_stream_tx

Interface
REQ-001 Parameter WIDTH, default 1: data beat width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 Parameter BURST, default 4: beats per burst; legal range 1..16.
REQ-004 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  reset; synchronous, active-low.
REQ-006 i_enable  input  1  permits a new burst to start.
REQ-007 i_push_valid  input  1  upstream beat offered.
REQ-008 i_push_data  input  WIDTH  upstream beat payload.
REQ-009 o_push_ready  output  1  FIFO can accept a beat.
REQ-010 o_tx_valid  output  1  beat presented to the interface consumer.
REQ-011 o_tx_data  output  WIDTH  beat payload, equal to the FIFO head.
REQ-012 o_tx_last  output  1  final beat of the current burst.
REQ-013 i_tx_ready  input  1  consumer accepts the beat.
REQ-014 o_count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-015 o_busy  output  1  high while the FSM is in BURST.

Function
REQ-016 A push SHALL occur when i_push_valid & o_push_ready; a pop SHALL occur when o_tx_valid & i_tx_ready.
REQ-017 o_push_ready SHALL equal (o_count != DEPTH); there is no bypass, so a full FIFO refuses a push even in a cycle with a simultaneous pop.
REQ-018 A simultaneous push and pop SHALL leave o_count unchanged; the pushed beat is written at the tail and the head advances.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly first-in, first-out.
REQ-020 The FSM SHALL have two states, IDLE and BURST.
REQ-021 IDLE to BURST: on i_enable=1 and o_count>=1; the first beat is presentable in the cycle after the transition.
REQ-022 In BURST, o_tx_valid SHALL equal (o_count != 0); in IDLE, o_tx_valid SHALL be 0.
REQ-023 Once o_tx_valid is high, o_tx_valid, o_tx_data and o_tx_last SHALL stay stable until the pop.
REQ-024 A beat counter (0..BURST-1) SHALL increment on each pop; o_tx_last SHALL equal o_tx_valid & (beat == BURST-1).
REQ-025 On a pop with o_tx_last=1, the counter SHALL clear to 0.
  - If i_enable=0 in that cycle, the FSM SHALL go to IDLE; otherwise it SHALL stay in BURST.
REQ-026 Deasserting i_enable mid-burst SHALL NOT truncate the burst; the FSM stays in BURST, stalling while the FIFO is empty, until the last beat pops.
REQ-027 With BURST=1, every beat SHALL carry o_tx_last=1.
REQ-028 Pushes SHALL be accepted in both states, independent of i_enable.
REQ-029 The design SHALL contain no combinational path from i_tx_ready to o_tx_valid, or from i_push_valid to o_push_ready.

Reset
REQ-030 While i_rst_n=0 at a clock edge, the block SHALL set:
  - FSM to IDLE; pointers, beat counter and o_count to 0.
  - Outputs: o_tx_valid=0, o_tx_last=0, o_busy=0, o_push_ready=1.
REQ-031 FIFO storage SHALL NOT be reset; o_tx_data is don't-care while o_tx_valid=0.
REQ-032 Reset asserted mid-burst SHALL discard all buffered beats and the partial burst; after release, the next beat carries beat index 0.

Verification
REQ-033 Push 0x1,0x0,0x1,0x1 (WIDTH=1, BURST=4), i_enable=1, i_tx_ready=1 -> four beats in order, o_tx_last only on the 4th, FSM returns to IDLE if i_enable=0 at that pop.
REQ-034 Push 5 beats with DEPTH=4, i_tx_ready=0 -> o_push_ready=0 after 4, o_count=4, 5th beat held upstream, no beat lost.
REQ-035 Full FIFO, push_valid=1 and a pop in the same cycle -> push refused, o_count goes 4 to 3, next cycle push accepted, o_count=4.
REQ-036 Drop i_enable after beat 2 of 4 -> beats 3 and 4 still sent, last on beat 4, then IDLE with remaining FIFO beats held.
REQ-037 Toggle i_tx_ready randomly for 100 beats, WIDTH=3 -> data order matches pushes, valid/data stable under stall, last every 4th beat.
REQ-038 Assert i_rst_n=0 mid-burst with o_count=3 -> next cycle o_count=0, o_tx_valid=0, FSM IDLE; the next burst begins at beat index 0.

Source files
------------

// File: rtl/generic_stream_tx.sv
// Burst-framed stream transmitter: a DEPTH-entry FIFO drained in BURST-beat bursts.
// A burst starts only on enable and always completes, stalling on an empty FIFO.
module generic_stream_tx #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_push_valid,
  input  logic [WIDTH-1:0]       i_push_data,
  output logic                   o_push_ready,
  output logic                   o_tx_valid,
  output logic [WIDTH-1:0]       o_tx_data,
  output logic                   o_tx_last,
  input  logic                   i_tx_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [BW-1:0]    beat_q;
  logic [BW-1:0]    beat_nxt;
  logic             valid_nxt;
  logic             last_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             do_push;
  logic             do_pop;

  // Handshakes use only registered flags, so ready/valid never depend on the peer.
  assign do_push   = i_push_valid & o_push_ready;
  assign do_pop    = o_tx_valid & i_tx_ready;
  assign o_tx_data = mem[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    beat_nxt   = beat_q;
    wr_ptr_nxt = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_nxt = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_nxt  = o_count + CW'(do_push) - CW'(do_pop);

    case (state_q)
      ST_IDLE: begin
        if (i_enable && (o_count != '0)) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (do_pop) begin
          if (o_tx_last) begin
            beat_nxt = '0;
            if (!i_enable) begin
              state_nxt = ST_IDLE;
            end
          end else begin
            beat_nxt = beat_q + BW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Output flags are precomputed from next-state values and then registered.
    valid_nxt = (state_nxt == ST_BURST) && (count_nxt != '0);
    last_nxt  = valid_nxt && (beat_nxt == BW'(BURST - 1));
    ready_nxt = (count_nxt != CW'(DEPTH));
    busy_nxt  = (state_nxt == ST_BURST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      o_count      <= '0;
      beat_q       <= '0;
      o_tx_valid   <= 1'b0;
      o_tx_last    <= 1'b0;
      o_push_ready <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_nxt;
      rd_ptr_q     <= rd_ptr_nxt;
      o_count      <= count_nxt;
      beat_q       <= beat_nxt;
      o_tx_valid   <= valid_nxt;
      o_tx_last    <= last_nxt;
      o_push_ready <= ready_nxt;
      o_busy       <= busy_nxt;
    end
  end

  // Storage is deliberately left unreset; contents are meaningless until written.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= i_push_data;
    end
  end

endmodule

// File: tb/tb_generic_stream_tx.sv
// Randomized scoreboard bench for generic_stream_tx against a queue-based reference model.
module tb_generic_stream_tx;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   enable;
  logic                   push_valid;
  logic [WIDTH-1:0]       push_data;
  logic                   push_ready;
  logic                   tx_valid;
  logic [WIDTH-1:0]       tx_data;
  logic                   tx_last;
  logic                   tx_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;

  generic_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_push_valid (push_valid),
    .i_push_data  (push_data),
    .o_push_ready (push_ready),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .o_tx_last    (tx_last),
    .i_tx_ready   (tx_ready),
    .o_count      (count),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: beats in flight, burst flag and position within the burst.
  logic [WIDTH-1:0] mq[$];
  bit               in_burst = 1'b0;
  int               beat = 0;
  bit               armed = 1'b0;
  int               pops_total = 0;
  bit               prev_valid = 1'b0;
  bit               prev_pop = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  logic [WIDTH-1:0] feed[$];
  bit               feed_rand = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    bit ev;
    bit el;
    bit er;
    bit dpop;
    bit dpush;
    ev = in_burst && (mq.size() != 0);
    el = ev && (beat == BURST - 1);
    er = (mq.size() != DEPTH);
    if (armed) begin
      check("tx_valid", tx_valid, ev);
      check("tx_last", tx_last, el);
      check("push_ready", push_ready, er);
      check("count", count, mq.size());
      check("busy", busy, in_burst);
      if (ev) check("tx_data", tx_data, mq[0]);
      if (prev_valid && !prev_pop) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, prev_data);
        check("stall_last", tx_last, prev_last);
      end
      prev_valid = tx_valid;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
    if (!rst_n) begin
      mq.delete();
      in_burst   = 1'b0;
      beat       = 0;
      armed      = 1'b1;
      prev_valid = 1'b0;
      prev_pop   = 1'b0;
    end else if (armed) begin
      dpop     = ev && tx_ready;
      dpush    = push_valid && er;
      prev_pop = dpop;
      if (in_burst) begin
        if (dpop) begin
          void'(mq.pop_front());
          pops_total++;
          if (beat == BURST - 1) begin
            beat = 0;
            if (!enable) in_burst = 1'b0;
          end else begin
            beat++;
          end
        end
      end else if (enable && (mq.size() != 0)) begin
        in_burst = 1'b1;
      end
      if (dpush) mq.push_back(push_data);
    end
  end

  // Feeder: offers queued beats upstream, advancing only on an observed handshake.
  initial begin
    push_valid = 1'b0;
    push_data  = '0;
    forever begin
      bit acc;
      @(negedge clk);
      acc = push_valid && push_ready;
      @(posedge clk);
      #1;
      if (acc && (feed.size() > 0)) void'(feed.pop_front());
      if ((feed.size() > 0) && (!feed_rand || ($urandom_range(3) != 0))) begin
        push_valid = 1'b1;
        push_data  = feed[0];
      end else begin
        push_valid = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed_rand_beats(input int n);
    for (int i = 0; i < n; i++) feed.push_back(WIDTH'($urandom));
  endtask

  initial begin
    int p0;
    int tgt;
    rst_n    = 1'b0;
    enable   = 1'b0;
    tx_ready = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Four beats buffered while idle, then a one-cycle enable launches one full burst.
    feed.push_back(3'd1);
    feed.push_back(3'd0);
    feed.push_back(3'd1);
    feed.push_back(3'd1);
    tx_ready = 1'b1;
    cycles(8);
    @(negedge clk);
    check("idle_count4", count, 4);
    check("idle_busy0", busy, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    cycles(1);
    enable = 1'b0;
    cycles(10);
    @(negedge clk);
    check("burst1_pops", pops_total, 4);
    check("burst1_idle", busy, 0);
    @(posedge clk); #1;

    // Overfill: fifth beat held upstream, then a pop while full refuses the push.
    tx_ready = 1'b0;
    feed_rand_beats(5);
    cycles(10);
    @(negedge clk);
    check("full_count", count, 4);
    check("full_ready", push_ready, 0);
    check("fifth_held", feed.size(), 1);
    @(posedge clk); #1;
    enable   = 1'b1;
    tx_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    check("full_pop_valid", tx_valid, 1);
    check("full_pop_refuse", push_ready, 0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("after_pop_count", count, 3);
    check("after_pop_ready", push_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("refill_count", count, 4);
    @(posedge clk); #1;

    // Enable held through a burst end keeps the FSM in BURST with nothing to send.
    tx_ready = 1'b1;
    feed_rand_beats(3);
    cycles(15);
    @(negedge clk);
    check("stay_busy", busy, 1);
    check("stay_empty", count, 0);
    @(posedge clk); #1;
    enable = 1'b0;
    feed_rand_beats(4);
    cycles(12);
    @(negedge clk);
    check("drain_idle", busy, 0);
    @(posedge clk); #1;

    // Enable dropped after beat 2 of 4: burst completes, two beats stay buffered.
    tx_ready = 1'b0;
    feed_rand_beats(6);
    cycles(10);
    p0 = pops_total;
    enable   = 1'b1;
    tx_ready = 1'b1;
    cycles(3);
    enable = 1'b0;
    cycles(20);
    @(negedge clk);
    check("trunc_pops", pops_total - p0, 4);
    check("trunc_count", count, 2);
    check("trunc_idle", busy, 0);
    @(posedge clk); #1;

    // Randomized backpressure and enable over 100 beats.
    feed_rand = 1'b1;
    feed_rand_beats(100);
    tgt = pops_total + 100;
    for (int k = 0; (k < 4000) && (pops_total < tgt); k++) begin
      tx_ready = 1'($urandom_range(1));
      enable   = ($urandom_range(3) != 0);
      cycles(1);
    end
    tests++;
    if (pops_total < tgt) begin
      fails++;
      $display("FAIL random_drain: popped %0d required %0d", pops_total, tgt);
    end
    feed_rand = 1'b0;

    // Reset in the middle of a burst with three beats buffered.
    enable   = 1'b1;
    tx_ready = 1'b1;
    cycles(30);
    tx_ready = 1'b0;
    feed.delete();
    feed_rand_beats(3);
    cycles(8);
    @(negedge clk);
    check("pre_rst_count", count, 3);
    check("pre_rst_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", push_ready, 1);
    @(posedge clk); #1;
    p0 = pops_total;
    feed_rand_beats(4);
    tx_ready = 1'b1;
    enable   = 1'b1;
    cycles(2);
    enable = 1'b0;
    cycles(15);
    @(negedge clk);
    check("post_rst_pops", pops_total - p0, 4);
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
